// File: rtl/serial_adder_n_pkg.sv
// Shared types and helpers for the digit-serial adder/subtractor.
package serial_adder_n_pkg;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StRun  = 2'd1,
        StDone = 2'd2
    } state_e;

    // Digit counter width: clog2 of the digit count, never below one bit.
    function automatic int unsigned cnt_width(input int unsigned n);
        return (n <= 1) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fa_chain.sv
// Combinational ripple of DIGIT full-adder cells; also exposes the carry into the top cell.
module fa_chain #(
    parameter int unsigned DIGIT = 1
) (
    input  logic [DIGIT-1:0] x,
    input  logic [DIGIT-1:0] y,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);

    logic [DIGIT:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_cell
        full_adder u_fa (
            .a  (x[i]),
            .b  (y[i]),
            .ci (c[i]),
            .s  (s[i]),
            .co (c[i+1])
        );
    end

    assign co    = c[DIGIT];
    assign c_msb = c[DIGIT-1];

endmodule

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/serial_adder_n.sv
// Digit-serial adder/subtractor: WIDTH-bit operands processed DIGIT bits per clock.
module serial_adder_n
    import serial_adder_n_pkg::*;
#(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             c_in,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             c_out,
    output logic             ovf
);

    if ((WIDTH < 1) || (DIGIT < 1) || (DIGIT > WIDTH) || ((WIDTH % DIGIT) != 0)) begin : g_bad_param
        $error("serial_adder_n: DIGIT must be in 1..WIDTH and divide WIDTH exactly");
    end

    localparam int unsigned N  = WIDTH / DIGIT;
    localparam int unsigned CW = cnt_width(N);

    state_e           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] acc_q;
    logic             carry_q;
    logic [CW-1:0]    cnt_q;

    logic [DIGIT-1:0] dig_s;
    logic             dig_co;
    logic             dig_cmsb;
    logic [WIDTH-1:0] acc_next;
    logic             last;

    fa_chain #(
        .DIGIT (DIGIT)
    ) u_chain (
        .x     (a_q[DIGIT-1:0]),
        .y     (b_q[DIGIT-1:0]),
        .ci    (carry_q),
        .s     (dig_s),
        .co    (dig_co),
        .c_msb (dig_cmsb)
    );

    // New digit enters from the MSB side; after N digits the LSB digit sits at bit 0.
    assign acc_next = (acc_q >> DIGIT) | (WIDTH'(dig_s) << (WIDTH - DIGIT));
    assign last     = (cnt_q == CW'(N - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            carry_q <= 1'b0;
            cnt_q   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sum     <= '0;
            c_out   <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state_q)
                StIdle, StDone: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub | c_in;
                        cnt_q   <= '0;
                        busy    <= 1'b1;
                        state_q <= StRun;
                    end else begin
                        state_q <= StIdle;
                    end
                end
                StRun: begin
                    a_q     <= a_q >> DIGIT;
                    b_q     <= b_q >> DIGIT;
                    acc_q   <= acc_next;
                    carry_q <= dig_co;
                    cnt_q   <= cnt_q + 1'b1;
                    if (last) begin
                        sum     <= acc_next;
                        c_out   <= dig_co;
                        // With DIGIT=1 the carry into the MSB is the carry flop itself.
                        ovf     <= dig_cmsb ^ dig_co;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        state_q <= StDone;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

endmodule

// File: doc/serial_adder_n.md
Name: serial_adder_n

Overview:
Parametrised digit-serial adder/subtractor. It is the sequential, multi-bit successor of the single-bit full adder.
- Adds or subtracts two WIDTH-bit operands, processing DIGIT bits per clock through a chain of full-adder cells.
- Uses a start/busy/done handshake and reports carry, result and signed overflow.
- Serves as the arithmetic core for later datapath exercises where area matters more than latency.

Parameters:
WIDTH, 8, operand and result width in bits; must be >= 1.
DIGIT, 1, bits processed per clock; must divide WIDTH exactly; N = WIDTH/DIGIT cycles per operation.

Ports:
clk  in  1  system clock, rising-edge active
rst_n  in  1  asynchronous reset, active low
start  in  1  request; sampled only when FSM is IDLE or DONE
sub  in  1  0 = a + b + c_in, 1 = a - b (b inverted, carry-in forced)
a  in  WIDTH  operand A, latched on accepted start
b  in  WIDTH  operand B, latched on accepted start
c_in  in  1  carry in; used only when sub=0
busy  out  1  high while an operation is in progress
done  out  1  one-cycle pulse when result becomes valid
sum  out  WIDTH  result, registered
c_out  out  1  carry out of MSB; in subtract mode 1 = no borrow
ovf  out  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Clock and reset: one clock. Reset is asynchronous and active-low (rst_n).
- Reset values: state=IDLE; busy=0, done=0, sum=0, c_out=0, ovf=0; internal shift registers, carry flop and digit counter cleared.
- FSM states: IDLE, RUN, DONE.
  - IDLE with start=1 -> RUN.
  - RUN when counter reaches N-1 -> DONE.
  - DONE always -> IDLE, unless start=1, then -> RUN.
- Accepted start (at edge E0):
  - latch a into A shift register;
  - latch (sub ? ~b : b) into B shift register;
  - carry flop = sub ? 1 : c_in;
  - counter = 0.
- RUN, each edge:
  - the low DIGIT bits of A and B plus the carry flop pass through the fa_chain;
  - the DIGIT-bit result shifts into the top of the partial-sum register from the MSB side;
  - A and B shift right by DIGIT;
  - the carry flop takes the chain carry-out;
  - counter increments.
- Last digit (edge EN, counter == N-1):
  - sum takes the fully assembled partial sum;
  - c_out takes the chain carry-out;
  - ovf = carry into bit WIDTH-1 XOR chain carry-out.
  - When DIGIT=1, the carry into the MSB is the carry flop value at that edge.
- Latency: done is high in the cycle following edge EN, i.e. N edges after the start edge. busy=1 exactly in the RUN cycles; busy=0 in IDLE and DONE.
- sum, c_out and ovf hold their value until the next completion. They do not change during RUN.
- start during RUN: ignored; no queueing.
- start during DONE: accepted (back-to-back operation). done still pulses that cycle, and busy rises next cycle.
- Operand inputs change during RUN: no effect.
- Reset mid-RUN: aborts immediately to reset values; no done pulse.
- Arithmetic is modulo 2^WIDTH; c_out carries the extra bit.
- Width rules:
  - counter width = clog2(N), minimum 1;
  - WIDTH=1, DIGIT=1 degenerates to a registered full adder with 1-cycle latency.

Decomposition:
- Shared package: state encoding localparams (IDLE, RUN, DONE).
- Parameter checks (WIDTH % DIGIT == 0, DIGIT <= WIDTH), flagged with an elaboration-time error.
- Sub-module fa_chain #(DIGIT): combinational ripple of DIGIT full-adder cells.
  - Ports: x[DIGIT], y[DIGIT], ci, s[DIGIT], co, c_msb (carry into top cell, for ovf).
  - It reuses the existing full-adder cell unchanged.

Test Plan:
1. WIDTH=1, DIGIT=1, sub=0; all 8 combinations of a, b, c_in in order 000..111 -> sum/c_out match the full-adder truth table; done 1 edge after each start; ovf = a&b&~c_in | ~a&~b&c_in.
2. WIDTH=8, DIGIT=1; a=0x7F, b=0x01, c_in=0 -> after 8 edges: done=1, sum=0x80, c_out=0, ovf=1; busy high exactly 8 cycles.
3. WIDTH=8, DIGIT=4, sub=1; a=0x05, b=0x07 -> after 2 edges: sum=0xFE, c_out=0 (borrow), ovf=0. Then a=0x80, b=0x01 -> sum=0x7F, c_out=1, ovf=1.
4. WIDTH=8, DIGIT=2; a=0xFF, b=0xFF, c_in=1 -> sum=0xFF, c_out=1, ovf=0. Pulse start mid-RUN with other operands -> ignored, result unchanged.
5. Back-to-back: assert start in the DONE cycle with a=0x10, b=0x20 -> first done pulse intact, busy next cycle, second done N edges later with sum=0x30.
6. Reset mid-operation: drop rst_n at RUN cycle 3 (asynchronously, between edges) -> busy, done, sum, c_out and ovf go to 0 immediately; no done pulse after release. A new start then completes normally.
